// File: rtl/sobol_seq_ctrl_pkg.sv
// Shared definitions for the Sobol sample sequencer.
//   state_t  : controller state encoding (IDLE / RUN / DONE)
//   LEN_CONT : sequence-length value that selects continuous mode
//   dir_vec  : direction vector k for a BITWIDTH-bit generator
package sobol_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LEN_CONT = 0;

  // v[k] = 1 << (bw-1-k): the MSB-first one-hot used for van der Corput order.
  function automatic logic [31:0] dir_vec(input int k, input int bw);
    return 32'd1 << (bw - 1 - k);
  endfunction

endpackage

// File: rtl/sobol_seq_ctrl_lsz.sv
// Least-significant-zero detector.
//   iGrey     : input word (the sample index n)
//   lszIdx    : bit position of the lowest 0 in iGrey (0 when iGrey is all ones)
//   lszOneHot : one-hot of that position (all zeros when iGrey is all ones)
module lsz
  import sobol_seq_ctrl_pkg::*;
#(
  parameter int BITWIDTH    = 4,
  parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
  input  logic [BITWIDTH-1:0]    iGrey,
  output logic [LOGBITWIDTH-1:0] lszIdx,
  output logic [BITWIDTH-1:0]    lszOneHot
);

  // Scan from MSB down so the last hit is the lowest zero.
  always_comb begin
    lszIdx    = '0;
    lszOneHot = '0;
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (!iGrey[i]) begin
        lszIdx       = LOGBITWIDTH'(i);
        lszOneHot    = '0;
        lszOneHot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobol_seq_ctrl.sv
// Sobol / van der Corput sample sequencer with valid/ready output.
//   iClk, iRst : clock, synchronous active-high reset
//   iStart     : begin a sequence (honoured in IDLE or DONE)
//   iStop      : abort the running sequence
//   iLen       : samples per sequence, latched on start; 0 = continuous
//   iReady     : downstream accepts the current sample
//   oValid     : oRand holds a valid sample (RUN)
//   oRand      : current sample x_n
//   oIdx       : current index n
//   oLszIdx    : direction index that the next transfer will use
//   oBusy      : high in RUN
//   oDone      : one-cycle pulse after the last sample of a finite sequence
module sobol_seq_ctrl
  import sobol_seq_ctrl_pkg::*;
#(
  parameter int BITWIDTH    = 4,
  parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic                   iStop,
  input  logic [BITWIDTH:0]      iLen,
  input  logic                   iReady,
  output logic                   oValid,
  output logic [BITWIDTH-1:0]    oRand,
  output logic [BITWIDTH-1:0]    oIdx,
  output logic [LOGBITWIDTH-1:0] oLszIdx,
  output logic                   oBusy,
  output logic                   oDone
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BITWIDTH-1:0]     r_rand;
  logic [BITWIDTH-1:0]     r_idx;
  logic [BITWIDTH:0]       r_cnt;
  logic [BITWIDTH:0]       r_len;
  logic [BITWIDTH:0]       w_cnt_inc;
  logic                    w_start;
  logic                    w_xfer;
  logic                    w_wrap;
  logic                    w_finite;
  logic [BITWIDTH-1:0]     w_dir;
  logic [BITWIDTH-1:0]     w_lsz_onehot;
  logic [LOGBITWIDTH-1:0]  w_lsz_idx;
  logic [BITWIDTH-1:0]     w_dir_tab [BITWIDTH];

  lsz #(
    .BITWIDTH    (BITWIDTH),
    .LOGBITWIDTH (LOGBITWIDTH)
  ) u_lsz (
    .iGrey     (r_idx),
    .lszIdx    (w_lsz_idx),
    .lszOneHot (w_lsz_onehot)
  );

  for (genvar k = 0; k < BITWIDTH; k++) begin : g_dir
    localparam logic [31:0] V = dir_vec(k, BITWIDTH);
    assign w_dir_tab[k] = V[BITWIDTH-1:0];
  end

  assign w_dir = w_dir_tab[w_lsz_idx];

  // An empty one-hot means n is all ones: lszIdx=0 is not a real direction,
  // so that transfer restarts the sequence instead of XORing v[0].
  assign w_wrap    = (w_lsz_onehot == '0);
  assign w_cnt_inc = r_cnt + (BITWIDTH + 1)'(1);
  assign w_finite  = (r_len != (BITWIDTH + 1)'(LEN_CONT));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // iStop beats both a transfer and completion; iStart is only honoured
  // outside RUN, and a simultaneous iStop keeps IDLE idle.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_xfer       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iStart && !iStop) begin
          w_start      = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (iStop) begin
          w_state_next = ST_IDLE;
        end else if (iReady) begin
          w_xfer = 1'b1;
          if (w_finite && (w_cnt_inc == r_len)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (iStart) begin
          w_start      = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rand <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
    end else if (w_start) begin
      r_rand <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_len  <= iLen;
    end else if (w_xfer) begin
      if (w_wrap) begin
        r_rand <= '0;
        r_idx  <= '0;
      end else begin
        r_rand <= r_rand ^ w_dir;
        r_idx  <= r_idx + BITWIDTH'(1);
      end
      r_cnt <= w_cnt_inc;
    end
  end

  assign oValid  = (r_state == ST_RUN);
  assign oBusy   = (r_state == ST_RUN);
  assign oDone   = (r_state == ST_DONE);
  assign oRand   = r_rand;
  assign oIdx    = r_idx;
  assign oLszIdx = w_lsz_idx;

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
module tb_sobol_seq_ctrl;

  localparam int BW     = 4;
  localparam int LBW    = 2;
  localparam int PERIOD = 16;

  logic           iClk;
  logic           iRst;
  logic           iStart;
  logic           iStop;
  logic [BW:0]    iLen;
  logic           iReady;
  logic           oValid;
  logic [BW-1:0]  oRand;
  logic [BW-1:0]  oIdx;
  logic [LBW-1:0] oLszIdx;
  logic           oBusy;
  logic           oDone;

  int n_checks = 0;
  int n_fail   = 0;

  sobol_seq_ctrl #(.BITWIDTH(BW), .LOGBITWIDTH(LBW)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iStop   (iStop),
    .iLen    (iLen),
    .iReady  (iReady),
    .oValid  (oValid),
    .oRand   (oRand),
    .oIdx    (oIdx),
    .oLszIdx (oLszIdx),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Sample m of the period: bit-reversed Gray code of m.
  function automatic logic [BW-1:0] sobol_ref(input int m);
    int            g;
    logic [BW-1:0] r;
    g = (m % PERIOD) ^ ((m % PERIOD) >> 1);
    r = '0;
    for (int b = 0; b < BW; b++) begin
      if (((g >> b) & 1) != 0) r[BW-1-b] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [LBW-1:0] lsz_ref(input int m);
    int k;
    if ((m % PERIOD) == PERIOD - 1) return '0;
    k = 0;
    while ((((m % PERIOD) >> k) & 1) == 1) k++;
    return LBW'(k);
  endfunction

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_seq(input int len);
    iLen   = (BW + 1)'(len);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0; iStop = 1'b0; iLen = '0; iReady = 1'b0;
    step(); step();
    iRst = 1'b0;
    step();
    n_checks++;
    if ({oValid, oBusy, oDone, oRand, oIdx} !== '0) begin
      n_fail++;
      $display("FAIL reset: got v=%b b=%b d=%b rand=%0d idx=%0d, want all 0",
               oValid, oBusy, oDone, oRand, oIdx);
    end
  endtask

  task automatic test_full_period();
    iReady = 1'b1;
    start_seq(PERIOD);
    for (int i = 0; i < PERIOD; i++) begin
      n_checks++;
      if (oValid !== 1'b1 || oRand !== sobol_ref(i) || oIdx !== BW'(i) ||
          oLszIdx !== lsz_ref(i) || oDone !== 1'b0) begin
        n_fail++;
        $display("FAIL full_period[%0d]: got v=%b rand=%0d idx=%0d lsz=%0d d=%b, want 1 %0d %0d %0d 0",
                 i, oValid, oRand, oIdx, oLszIdx, oDone, sobol_ref(i), i, lsz_ref(i));
      end
      step();
    end
    n_checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_period_done: got d=%b v=%b, want d=1 v=0", oDone, oValid);
    end
    step();
    n_checks++;
    if (oDone !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_period_idle: got d=%b v=%b b=%b, want 0 0 0", oDone, oValid, oBusy);
    end
  endtask

  task automatic test_backpressure();
    iReady = 1'b1;
    start_seq(PERIOD);
    for (int i = 0; i < 5; i++) step();
    iReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (oValid !== 1'b1 || oRand !== 4'd14 || oIdx !== 4'd5 || oLszIdx !== 2'd1) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got v=%b rand=%0d idx=%0d lsz=%0d, want 1 14 5 1",
                 c, oValid, oRand, oIdx, oLszIdx);
      end
    end
    iReady = 1'b1;
    step();
    n_checks++;
    if (oRand !== 4'd10 || oIdx !== 4'd6) begin
      n_fail++;
      $display("FAIL backpressure_resume: got rand=%0d idx=%0d, want 10 6", oRand, oIdx);
    end
    for (int i = 6; i < PERIOD; i++) step();
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_done: got d=%b, want 1", oDone);
    end
    step();
  endtask

  task automatic test_random_len(input int len);
    int xfers = 0;
    int cyc   = 0;
    iReady = 1'b0;
    start_seq(len);
    while (xfers < len && cyc < 400) begin
      n_checks++;
      if (oValid !== 1'b1 || oRand !== sobol_ref(xfers) || oIdx !== BW'(xfers % PERIOD) ||
          oDone !== 1'b0) begin
        n_fail++;
        $display("FAIL random_len%0d[%0d]: got v=%b rand=%0d idx=%0d d=%b, want 1 %0d %0d 0",
                 len, xfers, oValid, oRand, oIdx, oDone, sobol_ref(xfers), xfers % PERIOD);
      end
      iReady = 1'($urandom_range(0, 1));
      step();
      cyc++;
      if (iReady) xfers++;
    end
    n_checks++;
    if (cyc >= 400 || oDone !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_len%0d_done: got d=%b v=%b cyc=%0d, want d=1 v=0 within 400",
               len, oDone, oValid, cyc);
    end
    iReady = 1'b1;
    step();
  endtask

  task automatic test_continuous();
    bit done_seen = 1'b0;
    iReady = 1'b1;
    start_seq(0);
    for (int i = 0; i < 40; i++) begin
      if (oDone) done_seen = 1'b1;
      n_checks++;
      if (oValid !== 1'b1 || oRand !== sobol_ref(i) || oIdx !== BW'(i % PERIOD)) begin
        n_fail++;
        $display("FAIL continuous[%0d]: got v=%b rand=%0d idx=%0d, want 1 %0d %0d",
                 i, oValid, oRand, oIdx, sobol_ref(i), i % PERIOD);
      end
      step();
    end
    n_checks++;
    if (done_seen !== 1'b0 || oDone !== 1'b0) begin
      n_fail++;
      $display("FAIL continuous_nodone: got done_seen=%b, want 0", done_seen);
    end
    iStop = 1'b1;
    step();
    iStop = 1'b0;
  endtask

  task automatic test_stop();
    iReady = 1'b1;
    start_seq(PERIOD);
    for (int i = 0; i < 6; i++) step();
    iStop = 1'b1;
    step();
    iStop = 1'b0;
    n_checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: got v=%b b=%b d=%b, want 0 0 0", oValid, oBusy, oDone);
    end
    step();
    n_checks++;
    if (oDone !== 1'b0 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: got d=%b v=%b, want 0 0", oDone, oValid);
    end
    start_seq(2);
    n_checks++;
    if (oValid !== 1'b1 || oRand !== 4'd0 || oIdx !== 4'd0) begin
      n_fail++;
      $display("FAIL stop_restart: got v=%b rand=%0d idx=%0d, want 1 0 0", oValid, oRand, oIdx);
    end
    step(); step();
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_restart_done: got d=%b, want 1", oDone);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] exp3 [3];
    exp3[0] = 4'd0; exp3[1] = 4'd8; exp3[2] = 4'd12;
    iReady = 1'b1;
    start_seq(PERIOD);
    for (int i = 0; i < 9; i++) step();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    n_checks++;
    if ({oValid, oBusy, oDone, oRand, oIdx} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b b=%b d=%b rand=%0d idx=%0d, want all 0",
               oValid, oBusy, oDone, oRand, oIdx);
    end
    start_seq(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (oValid !== 1'b1 || oRand !== exp3[i]) begin
        n_fail++;
        $display("FAIL reset_mid_len3[%0d]: got v=%b rand=%0d, want 1 %0d", i, oValid, oRand, exp3[i]);
      end
      step();
    end
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_done: got d=%b, want 1", oDone);
    end
    step();
  endtask

  task automatic test_len1();
    iReady = 1'b1;
    start_seq(1);
    n_checks++;
    if (oValid !== 1'b1 || oRand !== 4'd0) begin
      n_fail++;
      $display("FAIL len1_sample: got v=%b rand=%0d, want 1 0", oValid, oRand);
    end
    step();
    n_checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_done: got d=%b v=%b, want 1 0", oDone, oValid);
    end
    step();
  endtask

  task automatic test_start_in_run();
    iReady = 1'b1;
    start_seq(6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (oValid !== 1'b1 || oRand !== sobol_ref(i) || oIdx !== BW'(i)) begin
        n_fail++;
        $display("FAIL start_in_run[%0d]: got v=%b rand=%0d idx=%0d, want 1 %0d %0d",
                 i, oValid, oRand, oIdx, sobol_ref(i), i);
      end
      iStart = (i == 2 || i == 3);
      iLen   = 5'd9;
      step();
    end
    iStart = 1'b0;
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run_done: got d=%b, want 1", oDone);
    end
    step();
  endtask

  task automatic test_start_in_done();
    iReady = 1'b1;
    start_seq(2);
    step(); step();
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_done_pulse: got d=%b, want 1", oDone);
    end
    start_seq(3);
    n_checks++;
    if (oValid !== 1'b1 || oRand !== 4'd0 || oIdx !== 4'd0 || oDone !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done_run: got v=%b rand=%0d idx=%0d d=%b, want 1 0 0 0",
               oValid, oRand, oIdx, oDone);
    end
    step(); step(); step();
    n_checks++;
    if (oDone !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_done_end: got d=%b, want 1", oDone);
    end
    step();
  endtask

  task automatic test_start_stop_idle();
    iLen = 5'd4; iStart = 1'b1; iStop = 1'b1;
    step();
    iStart = 1'b0; iStop = 1'b0;
    n_checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle: got v=%b b=%b, want 0 0", oValid, oBusy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_period();
    test_backpressure();
    test_continuous();
    test_stop();
    test_reset_mid();
    test_len1();
    test_start_in_run();
    test_start_in_done();
    test_start_stop_idle();
    test_random_len(PERIOD + 3);
    for (int r = 0; r < 3; r++) test_random_len(int'($urandom_range(1, 31)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
